// File: rtl/wb_regfile_pkg.sv
// ----------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared pipeline definitions for the write-back stage and register file:
//   data/index widths, register count, write-back source encodings and a
//   small helper that decides whether a read port hits the in-flight write.
// ----------------------------------------------------------------------------
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 6;
    localparam int NUM_REGS = 64;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_AW-1:0] ridx_t;

    // Write-back source select. The fourth code is reserved and falls back
    // to the ALU result.
    typedef enum logic [1:0] {
        SEL_ALU   = 2'b00,
        SEL_MEM   = 2'b01,
        SEL_PCIMM = 2'b10,
        SEL_RSVD  = 2'b11
    } wb_sel_e;

    // A read port forwards the write-back value only when a real write is
    // happening to the same, non-zero register.
    function automatic logic bypass_hit(input ridx_t rs, input ridx_t rd,
                                        input logic en);
        return en && (rs == rd) && (rs != '0);
    endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// ----------------------------------------------------------------------------
// wb_mux
//   Write-back source multiplexer. Purely combinational.
//   Ports:
//     sel    - 2-bit source select (wb_sel_e encoding)
//     alu    - ALU result
//     mem    - load data
//     pcimm  - PC + immediate
//     data   - selected write-back value
// ----------------------------------------------------------------------------
module wb_mux
    import wb_regfile_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] mem,
    input  logic [DATA_W-1:0] pcimm,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = alu;
        case (wb_sel_e'(sel))
            SEL_MEM:   data = mem;
            SEL_PCIMM: data = pcimm;
            default:   data = alu;   // SEL_ALU and the reserved code
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage plus 64 x 32 register file with same-cycle bypass and
//   architectural Z/N flag registers.
//   Ports:
//     CLK, RESET            - clock, synchronous active-high reset
//     PCwIMM_in, ALU_res_in,
//     ReadData_in           - write-back candidates from MEM/WB
//     Rd_in, RegWrite_in    - destination index and write request
//     ThreeWay_in           - write-back source select
//     Z_in, N_in            - flags of the retiring instruction
//     Rs1, Rs2              - decode-stage read indices
//     RD1, RD2              - read data (combinational, bypassed)
//     WB_data, WB_Rd, WB_en - selected value / index / effective enable
//     Z_flag, N_flag        - architectural flags
// ----------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] PCwIMM_in,
    input  logic [DATA_W-1:0] ALU_res_in,
    input  logic [DATA_W-1:0] ReadData_in,
    input  logic [REG_AW-1:0] Rd_in,
    input  logic              RegWrite_in,
    input  logic [1:0]        ThreeWay_in,
    input  logic              Z_in,
    input  logic              N_in,
    input  logic [REG_AW-1:0] Rs1,
    input  logic [REG_AW-1:0] Rs2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] WB_data,
    output logic [REG_AW-1:0] WB_Rd,
    output logic              WB_en,
    output logic              Z_flag,
    output logic              N_flag
);

    word_t regs [NUM_REGS];
    ridx_t rs_idx [2];
    word_t rd_val [2];

    wb_mux u_wb_mux (
        .sel   (ThreeWay_in),
        .alu   (ALU_res_in),
        .mem   (ReadData_in),
        .pcimm (PCwIMM_in),
        .data  (WB_data)
    );

    // Register 0 is excluded here so it never holds anything but zero, and
    // RESET gates the enable so a write-back in a reset cycle is dropped
    // and cannot be forwarded.
    assign WB_en = RegWrite_in && (Rd_in != '0) && !RESET;
    assign WB_Rd = Rd_in;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            Z_flag <= 1'b0;
            N_flag <= 1'b0;
        end else begin
            if (WB_en) regs[Rd_in] <= WB_data;
            Z_flag <= Z_in;
            N_flag <= N_in;
        end
    end

    assign rs_idx[0] = Rs1;
    assign rs_idx[1] = Rs2;

    // Two independent read ports; index 0 always reads zero, otherwise the
    // in-flight write-back takes priority over stored contents.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = '0;
            if (rs_idx[p] == '0)
                rd_val[p] = '0;
            else if (bypass_hit(rs_idx[p], Rd_in, WB_en))
                rd_val[p] = WB_data;
            else
                rd_val[p] = regs[rs_idx[p]];
        end
    end

    assign RD1 = rd_val[0];
    assign RD2 = rd_val[1];

endmodule

// File: tb/tb_wb_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile
//   Directed bench for wb_regfile. Expected values are pushed to a scoreboard
//   queue as stimulus is applied and popped when the DUT output is sampled.
// ----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PCwIMM_in, ALU_res_in, ReadData_in;
    logic [5:0]  Rd_in;
    logic        RegWrite_in;
    logic [1:0]  ThreeWay_in;
    logic        Z_in, N_in;
    logic [5:0]  Rs1, Rs2;
    logic [31:0] RD1, RD2, WB_data;
    logic [5:0]  WB_Rd;
    logic        WB_en, Z_flag, N_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb [$];

    always #5 CLK = ~CLK;

    wb_regfile dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PCwIMM_in   (PCwIMM_in),
        .ALU_res_in  (ALU_res_in),
        .ReadData_in (ReadData_in),
        .Rd_in       (Rd_in),
        .RegWrite_in (RegWrite_in),
        .ThreeWay_in (ThreeWay_in),
        .Z_in        (Z_in),
        .N_in        (N_in),
        .Rs1         (Rs1),
        .Rs2         (Rs2),
        .RD1         (RD1),
        .RD2         (RD2),
        .WB_data     (WB_data),
        .WB_Rd       (WB_Rd),
        .WB_en       (WB_en),
        .Z_flag      (Z_flag),
        .N_flag      (N_flag)
    );

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance past the next rising edge; outputs are sampled away from it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] src_exp [4];
        src_exp[0] = 32'h11; src_exp[1] = 32'h22;
        src_exp[2] = 32'h33; src_exp[3] = 32'h11;

        RESET = 1'b1; PCwIMM_in = '0; ALU_res_in = '0; ReadData_in = '0;
        Rd_in = '0; RegWrite_in = 1'b0; ThreeWay_in = 2'b00;
        Z_in = 1'b0; N_in = 1'b0; Rs1 = '0; Rs2 = '0;
        step();

        // Reset state
        RESET = 1'b0; Rs1 = 6'd5; Rs2 = 6'd9;
        expect_val("reset_rd1", 32'h0);
        expect_val("reset_rd2", 32'h0);
        expect_val("reset_z",   32'h0);
        expect_val("reset_n",   32'h0);
        #1;
        check(RD1); check(RD2); check({31'b0, Z_flag}); check({31'b0, N_flag});

        // Source select, each value read back from storage after the edge
        for (int s = 0; s < 4; s++) begin
            ALU_res_in = 32'h11; ReadData_in = 32'h22; PCwIMM_in = 32'h33;
            RegWrite_in = 1'b1; Rd_in = 6'd5; ThreeWay_in = s[1:0]; Rs1 = 6'd0;
            expect_val($sformatf("sel%0d_wbdata", s), src_exp[s]);
            expect_val($sformatf("sel%0d_wben", s), 32'h1);
            expect_val($sformatf("sel%0d_wbrd", s), 32'h5);
            #1;
            check(WB_data); check({31'b0, WB_en}); check({26'b0, WB_Rd});
            expect_val($sformatf("sel%0d_stored", s), src_exp[s]);
            step();
            RegWrite_in = 1'b0; Rs1 = 6'd5;
            #1;
            check(RD1);
        end

        // Same-cycle bypass on both ports; reg 7 still holds 0 in storage
        RegWrite_in = 1'b1; Rd_in = 6'd7; ALU_res_in = 32'hDEADBEEF;
        ThreeWay_in = 2'b00; Rs1 = 6'd7; Rs2 = 6'd7;
        expect_val("bypass_rd1", 32'hDEADBEEF);
        expect_val("bypass_rd2", 32'hDEADBEEF);
        #1;
        check(RD1); check(RD2);
        step();
        RegWrite_in = 1'b0; Rs1 = 6'd7; Rs2 = 6'd5;
        expect_val("bypass_stored", 32'hDEADBEEF);
        expect_val("other_port_r5", 32'h11);
        #1;
        check(RD1); check(RD2);

        // Writes to register 0 are ignored
        RegWrite_in = 1'b1; Rd_in = 6'd0; ALU_res_in = 32'hFFFFFFFF;
        Rs1 = 6'd0; Rs2 = 6'd0;
        expect_val("r0_wben", 32'h0);
        expect_val("r0_rd1_before", 32'h0);
        expect_val("r0_rd2_before", 32'h0);
        #1;
        check({31'b0, WB_en}); check(RD1); check(RD2);
        step();
        RegWrite_in = 1'b0;
        expect_val("r0_rd1_after", 32'h0);
        #1;
        check(RD1);

        // Back-to-back writes to reg 3: newer value forwarded, then stored
        RegWrite_in = 1'b1; Rd_in = 6'd3; ALU_res_in = 32'hA; Rs1 = 6'd3;
        step();
        ALU_res_in = 32'hB;
        expect_val("b2b_bypass", 32'hB);
        #1;
        check(RD1);
        step();
        RegWrite_in = 1'b0;
        expect_val("b2b_stored", 32'hB);
        #1;
        check(RD1);

        // Flags, one cycle after the input
        Z_in = 1'b1; N_in = 1'b0;
        step();
        expect_val("flags1_z", 32'h1); expect_val("flags1_n", 32'h0);
        #1;
        check({31'b0, Z_flag}); check({31'b0, N_flag});
        Z_in = 1'b0; N_in = 1'b1;
        expect_val("flags_hold_z", 32'h1);
        #1;
        check({31'b0, Z_flag});
        step();
        expect_val("flags2_z", 32'h0); expect_val("flags2_n", 32'h1);
        #1;
        check({31'b0, Z_flag}); check({31'b0, N_flag});

        // Reset mid-operation
        RegWrite_in = 1'b1; Rd_in = 6'd9; ALU_res_in = 32'h55; Z_in = 1'b1;
        step();
        RegWrite_in = 1'b0; Rs1 = 6'd9;
        expect_val("pre_reset_r9", 32'h55); expect_val("pre_reset_z", 32'h1);
        #1;
        check(RD1); check({31'b0, Z_flag});
        RESET = 1'b1; RegWrite_in = 1'b1; Rd_in = 6'd9; ALU_res_in = 32'h66;
        expect_val("rst_wben", 32'h0);
        expect_val("rst_rd1_nobypass", 32'h55);
        expect_val("rst_wbdata", 32'h66);
        expect_val("rst_wbrd", 32'h9);
        #1;
        check({31'b0, WB_en}); check(RD1); check(WB_data); check({26'b0, WB_Rd});
        step();
        RESET = 1'b0; RegWrite_in = 1'b0; Z_in = 1'b0; Rs2 = 6'd7;
        expect_val("post_reset_r9", 32'h0);
        expect_val("post_reset_r7", 32'h0);
        expect_val("post_reset_z", 32'h0);
        #1;
        check(RD1); check(RD2); check({31'b0, Z_flag});

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover count=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have ports PCwIMM_in, ALU_res_in and ReadData_in, each input, 32 bits: write-back candidates from the MEM/WB pipeline register.
REQ-004 SHALL have port Rd_in, input, 6 bits: destination register index.
REQ-005 SHALL have port RegWrite_in, input, 1 bit: write-back request.
REQ-006 SHALL have port ThreeWay_in, input, 2 bits: write-back source select.
REQ-007 SHALL have ports Z_in and N_in, input, 1 bit each: zero and negative flags of the retiring instruction.
REQ-008 SHALL have ports Rs1 and Rs2, input, 6 bits each: decode-stage read indices.
REQ-009 SHALL have ports RD1 and RD2, output, 32 bits each: read data for Rs1 and Rs2.
REQ-010 SHALL have port WB_data, output, 32 bits: selected write-back value, provided for forwarding.
REQ-011 SHALL have ports WB_Rd (output, 6 bits) and WB_en (output, 1 bit): effective write index and effective write enable.
REQ-012 SHALL have ports Z_flag and N_flag, output, 1 bit each: architectural flag registers.

Function
REQ-013 SHALL hold 64 registers of 32 bits each, with register 0 hardwired to read 0.
REQ-014 SHALL drive WB_data combinationally from ThreeWay_in:
- 00 -> ALU_res_in
- 01 -> ReadData_in
- 10 -> PCwIMM_in
- 11 (reserved) -> ALU_res_in
REQ-015 SHALL drive WB_en = RegWrite_in AND (Rd_in != 0) AND NOT RESET, and WB_Rd = Rd_in.
REQ-016 SHALL write WB_data into register Rd_in at the rising edge when WB_en=1; the write has 1-cycle latency.
REQ-017 SHALL read RD1 and RD2 combinationally, with 0 latency.
REQ-018 SHALL bypass on a same-cycle hazard: when WB_en=1 and Rs1==Rd_in, RD1 SHALL equal WB_data in that cycle; the same rule applies to Rs2 and RD2.
REQ-019 SHALL return 0 on RD1 or RD2 for an index of 0, with no bypass, regardless of any write to 0.
REQ-020 SHALL serve Rs1==Rs2 from independent ports, giving identical values.
REQ-021 SHALL load Z_flag<=Z_in and N_flag<=N_in on every rising edge when RESET=0, giving 1-cycle latency.
REQ-022 SHALL ignore any write with RegWrite_in=1 and Rd_in=0; no state changes.
REQ-023 SHALL let the last write win across back-to-back writes to the same index; a read in the following cycle returns the newer value, via bypass if it is still in write-back.

Reset
REQ-024 SHALL, at a rising edge with RESET=1, clear all 64 registers, Z_flag and N_flag to 0.
REQ-025 SHALL suppress writes and bypass while RESET=1 (per REQ-015); a write-back present in a reset cycle is discarded.
REQ-026 SHALL keep RD1 and RD2 as combinational reads of stored contents during RESET=1; after the reset edge all reads return 0.
REQ-027 SHALL drive WB_data and WB_Rd as pure functions of their inputs, unaffected by RESET.

Structure
REQ-028 SHALL place the following in a shared pipeline package:
- DATA_W=32, REG_AW=6, NUM_REGS=64
- ThreeWay encodings: SEL_ALU=00, SEL_MEM=01, SEL_PCIMM=10
REQ-029 SHALL implement the write-back source mux as the single sub-module wb_mux; register storage, bypass and flags SHALL stay in wb_regfile.

Verification
REQ-030 SHALL cover source select: ThreeWay 00/01/10/11 with ALU=0x11, Mem=0x22, PC=0x33, RegWrite=1, Rd=5 -> after each edge, Rs1=5 reads 0x11/0x22/0x33/0x11 respectively.
REQ-031 SHALL cover bypass: Rd=7, RegWrite=1, ALU=0xDEADBEEF, ThreeWay=00, Rs1=7, Rs2=7 in the same cycle -> RD1=RD2=0xDEADBEEF before the edge.
REQ-032 SHALL cover register 0: RegWrite=1, Rd=0, ALU=0xFFFFFFFF -> WB_en=0, and Rs1=0 reads 0 before and after the edge.
REQ-033 SHALL cover back-to-back writes: Rd=3 with 0xA, then Rd=3 with 0xB, then RegWrite=0 -> Rs1=3 reads 0xB.
REQ-034 SHALL cover reset mid-operation: reg 9=0x55 and Z_in=1 latched, then RESET=1 together with a write of 0x66 to reg 9 -> after the edge reg 9 reads 0, Z_flag=0, WB_en=0 during reset.
REQ-035 SHALL cover flags: Z_in=1, N_in=0, then Z_in=0, N_in=1 -> Z_flag/N_flag read 1/0, then 0/1, each one cycle after the input.
